// File: rtl/mir_pkg.sv
// Shared definitions for the pipelined microinstruction register: default field widths,
// field offset helpers, controller states and the NOP word.
package mir_pkg;

    localparam int unsigned DefRegWidth   = 6;
    localparam int unsigned DefAluWidth   = 4;
    localparam int unsigned DefCondWidth  = 3;
    localparam int unsigned DefJumpWidth  = 11;
    localparam int unsigned DefMemTimeout = 16;

    function automatic int unsigned mir_width(input int unsigned reg_w, input int unsigned alu_w,
                                              input int unsigned cond_w,
                                              input int unsigned jump_w);
        return 3 * reg_w + 5 + alu_w + cond_w + jump_w;
    endfunction

    // Fields are packed MSB first: A, AMUX, B, BMUX, C, CMUX, RD, WR, ALU, COND, JUMP_ADDR.
    function automatic int unsigned wr_pos(input int unsigned alu_w, input int unsigned cond_w,
                                           input int unsigned jump_w);
        return jump_w + cond_w + alu_w;
    endfunction

    localparam int unsigned DefMirWidth =
        mir_width(DefRegWidth, DefAluWidth, DefCondWidth, DefJumpWidth);
    localparam int unsigned DefCondLsb  = DefJumpWidth;
    localparam int unsigned DefAluLsb   = DefCondLsb + DefCondWidth;
    localparam int unsigned DefWrBit    = wr_pos(DefAluWidth, DefCondWidth, DefJumpWidth);
    localparam int unsigned DefRdBit    = DefWrBit + 1;

    typedef enum logic [1:0] {
        StExec,
        StMemWait,
        StErr
    } mir_state_e;

    function automatic logic [DefMirWidth-1:0] mir_nop();
        return '0;
    endfunction

endpackage

// File: rtl/mir_mem_watchdog.sv
// Memory-wait cycle counter; expired flags the last permitted wait cycle so the
// controller can trap a missing acknowledge.
module mir_mem_watchdog
    import mir_pkg::*;
#(
    parameter int unsigned MemTimeout = DefMemTimeout
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CntWidth = $clog2(MemTimeout + 1);

    logic [CntWidth-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CntWidth'(1);
        end
    end

    always_ff @(negedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == CntWidth'(MemTimeout - 1));

endmodule

// File: rtl/mir_pipe_ctrl.sv
// Microinstruction register that holds its word across memory accesses, stalls the MPC,
// inserts NOPs on flush and traps illegal or timed-out accesses. State changes on negedge.
module mir_pipe_ctrl
    import mir_pkg::*;
#(
    parameter int unsigned REG_BUS_WIDTH       = DefRegWidth,
    parameter int unsigned ALU_BUS_WIDTH       = DefAluWidth,
    parameter int unsigned COND_BUS_WIDTH      = DefCondWidth,
    parameter int unsigned JUMP_ADDR_BUS_WIDTH = DefJumpWidth,
    parameter int unsigned MEM_TIMEOUT         = DefMemTimeout,
    localparam int unsigned MIR_BUS_WIDTH =
        mir_width(REG_BUS_WIDTH, ALU_BUS_WIDTH, COND_BUS_WIDTH, JUMP_ADDR_BUS_WIDTH)
) (
    input  logic                           MIRP_CLOCK_50,
    input  logic                           SC_RegGENERAL_Reset_InHigh,
    input  logic [MIR_BUS_WIDTH-1:0]       MIRP_Microinstruccion_IN,
    input  logic                           MIRP_Load_InHigh,
    input  logic                           MIRP_Flush_InHigh,
    input  logic                           MIRP_MemAck_InHigh,
    output logic [REG_BUS_WIDTH-1:0]       MIRP_A_OUT,
    output logic [REG_BUS_WIDTH-1:0]       MIRP_B_OUT,
    output logic [REG_BUS_WIDTH-1:0]       MIRP_C_OUT,
    output logic                           MIRP_AMUX_OUT,
    output logic                           MIRP_BMUX_OUT,
    output logic                           MIRP_CMUX_OUT,
    output logic                           MIRP_RD_OUT,
    output logic                           MIRP_WR_OUT,
    output logic [ALU_BUS_WIDTH-1:0]       MIRP_ALU_OUT,
    output logic [COND_BUS_WIDTH-1:0]      MIRP_COND_OUT,
    output logic [JUMP_ADDR_BUS_WIDTH-1:0] MIRP_JUMP_ADDR_OUT,
    output logic                           MIRP_Valid_OUT,
    output logic                           MIRP_Ready_OUT,
    output logic                           MIRP_MemErr_OUT
);

    localparam int unsigned CondLsb = JUMP_ADDR_BUS_WIDTH;
    localparam int unsigned AluLsb  = CondLsb + COND_BUS_WIDTH;
    localparam int unsigned WrBit   = wr_pos(ALU_BUS_WIDTH, COND_BUS_WIDTH, JUMP_ADDR_BUS_WIDTH);
    localparam int unsigned RdBit   = WrBit + 1;
    localparam int unsigned CmuxBit = RdBit + 1;
    localparam int unsigned CLsb    = CmuxBit + 1;
    localparam int unsigned BmuxBit = CLsb + REG_BUS_WIDTH;
    localparam int unsigned BLsb    = BmuxBit + 1;
    localparam int unsigned AmuxBit = BLsb + REG_BUS_WIDTH;
    localparam int unsigned ALsb    = AmuxBit + 1;

    localparam logic [MIR_BUS_WIDTH-1:0] Nop = '0;

    mir_state_e               state_q, state_d;
    logic [MIR_BUS_WIDTH-1:0] mir_q, mir_d;
    logic [MIR_BUS_WIDTH-1:0] load_word;
    logic                     valid_q, valid_d;
    logic                     pend_q, pend_d;
    logic                     insert_nop;
    logic                     wd_clear, wd_enable, wd_expired;

    mir_mem_watchdog #(
        .MemTimeout (MEM_TIMEOUT)
    ) u_watchdog (
        .clk_i     (MIRP_CLOCK_50),
        .rst_i     (SC_RegGENERAL_Reset_InHigh),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d    = state_q;
        mir_d      = mir_q;
        valid_d    = valid_q;
        pend_d     = pend_q;
        wd_clear   = 1'b0;
        wd_enable  = 1'b0;
        insert_nop = MIRP_Flush_InHigh | pend_q;
        load_word  = insert_nop ? Nop : MIRP_Microinstruccion_IN;
        unique case (state_q)
            StExec: begin
                wd_clear = 1'b1;
                if (MIRP_Load_InHigh) begin
                    mir_d   = load_word;
                    valid_d = ~insert_nop;
                    pend_d  = 1'b0;
                    if (load_word[RdBit] && load_word[WrBit]) begin
                        state_d = StErr;
                        mir_d   = Nop;
                        valid_d = 1'b0;
                    end else if (load_word[RdBit] ^ load_word[WrBit]) begin
                        state_d = StMemWait;
                    end
                end else if (MIRP_Flush_InHigh) begin
                    pend_d = 1'b1;
                end
            end
            StMemWait: begin
                if (MIRP_Flush_InHigh) begin
                    pend_d = 1'b1;
                end
                // An ack on the final allowed cycle still completes the access.
                if (MIRP_MemAck_InHigh) begin
                    mir_d[RdBit] = 1'b0;
                    mir_d[WrBit] = 1'b0;
                    wd_clear     = 1'b1;
                    state_d      = StExec;
                end else if (wd_expired) begin
                    mir_d    = Nop;
                    valid_d  = 1'b0;
                    wd_clear = 1'b1;
                    state_d  = StErr;
                end else begin
                    wd_enable = 1'b1;
                end
            end
            StErr: begin
                mir_d    = Nop;
                valid_d  = 1'b0;
                wd_clear = 1'b1;
            end
            default: begin
                mir_d   = Nop;
                valid_d = 1'b0;
                state_d = StErr;
            end
        endcase
    end

    always_ff @(negedge MIRP_CLOCK_50) begin
        if (SC_RegGENERAL_Reset_InHigh) begin
            state_q <= StExec;
            mir_q   <= Nop;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mir_q   <= mir_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
        end
    end

    assign MIRP_A_OUT         = mir_q[ALsb +: REG_BUS_WIDTH];
    assign MIRP_AMUX_OUT      = mir_q[AmuxBit];
    assign MIRP_B_OUT         = mir_q[BLsb +: REG_BUS_WIDTH];
    assign MIRP_BMUX_OUT      = mir_q[BmuxBit];
    assign MIRP_C_OUT         = mir_q[CLsb +: REG_BUS_WIDTH];
    assign MIRP_CMUX_OUT      = mir_q[CmuxBit];
    assign MIRP_RD_OUT        = mir_q[RdBit];
    assign MIRP_WR_OUT        = mir_q[WrBit];
    assign MIRP_ALU_OUT       = mir_q[AluLsb +: ALU_BUS_WIDTH];
    assign MIRP_COND_OUT      = mir_q[CondLsb +: COND_BUS_WIDTH];
    assign MIRP_JUMP_ADDR_OUT = mir_q[JUMP_ADDR_BUS_WIDTH-1:0];
    assign MIRP_Valid_OUT     = valid_q;
    assign MIRP_Ready_OUT     = (state_q == StExec);
    assign MIRP_MemErr_OUT    = (state_q == StErr);

endmodule

// File: tb/tb_mir_pipe_ctrl.sv
// Self-checking bench for mir_pipe_ctrl: directed vector table, multi-cycle corner
// sequences and a randomized run against a behavioural model.
module tb_mir_pipe_ctrl;

    localparam int unsigned W       = 41;
    localparam int unsigned TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         rst, load, flush, ack;
    logic [W-1:0] word_in;
    logic [5:0]   a_o, b_o, c_o;
    logic         amux_o, bmux_o, cmux_o, rd_o, wr_o;
    logic [3:0]   alu_o;
    logic [2:0]   cond_o;
    logic [10:0]  jump_o;
    logic         valid_o, ready_o, err_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mir_pipe_ctrl #(
        .REG_BUS_WIDTH       (6),
        .ALU_BUS_WIDTH       (4),
        .COND_BUS_WIDTH      (3),
        .JUMP_ADDR_BUS_WIDTH (11),
        .MEM_TIMEOUT         (TIMEOUT)
    ) dut (
        .MIRP_CLOCK_50              (clk),
        .SC_RegGENERAL_Reset_InHigh (rst),
        .MIRP_Microinstruccion_IN   (word_in),
        .MIRP_Load_InHigh           (load),
        .MIRP_Flush_InHigh          (flush),
        .MIRP_MemAck_InHigh         (ack),
        .MIRP_A_OUT                 (a_o),
        .MIRP_B_OUT                 (b_o),
        .MIRP_C_OUT                 (c_o),
        .MIRP_AMUX_OUT              (amux_o),
        .MIRP_BMUX_OUT              (bmux_o),
        .MIRP_CMUX_OUT              (cmux_o),
        .MIRP_RD_OUT                (rd_o),
        .MIRP_WR_OUT                (wr_o),
        .MIRP_ALU_OUT               (alu_o),
        .MIRP_COND_OUT              (cond_o),
        .MIRP_JUMP_ADDR_OUT         (jump_o),
        .MIRP_Valid_OUT             (valid_o),
        .MIRP_Ready_OUT             (ready_o),
        .MIRP_MemErr_OUT            (err_o)
    );

    function automatic logic [W-1:0] mk(input logic [5:0] a, input logic amux,
                                        input logic [5:0] b, input logic bmux,
                                        input logic [5:0] c, input logic cmux,
                                        input logic rd, input logic wr,
                                        input logic [3:0] alu, input logic [2:0] cond,
                                        input logic [10:0] jump);
        return {a, amux, b, bmux, c, cmux, rd, wr, alu, cond, jump};
    endfunction

    function automatic logic [W+2:0] observed();
        return {valid_o, ready_o, err_o, a_o, amux_o, b_o, bmux_o, c_o, cmux_o, rd_o, wr_o,
                alu_o, cond_o, jump_o};
    endfunction

    task automatic chk(input string name, input logic [W+2:0] exp);
        logic [W+2:0] act;
        act = observed();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {valid,ready,err,word}=%h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic l, input logic f, input logic a,
                       input logic [W-1:0] w);
        rst = r; load = l; flush = f; ack = a; word_in = w;
        @(negedge clk);
        #1;
    endtask

    // Behavioural reference: m_age < 0 means no access outstanding.
    logic         m_dead, m_pend, m_valid;
    int           m_age;
    logic [W-1:0] m_word;

    task automatic model_step(input logic r, input logic l, input logic f, input logic a,
                              input logic [W-1:0] w);
        logic [W-1:0] rw;
        rw = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        if (r) begin
            m_dead = 0; m_pend = 0; m_valid = 0; m_age = -1; m_word = '0;
        end else if (m_dead) begin
            m_word = '0;
        end else if (m_age >= 0) begin
            if (f) m_pend = 1;
            if (a) begin
                m_word = m_word & ~rw;
                m_age  = -1;
            end else begin
                m_age++;
                if (m_age >= TIMEOUT) begin
                    m_dead = 1; m_word = '0; m_valid = 0;
                end
            end
        end else if (l) begin
            if (f || m_pend) begin
                m_word = '0; m_valid = 0;
            end else begin
                m_word = w; m_valid = 1;
            end
            m_pend = 0;
            if ((m_word & rw) == rw) begin
                m_dead = 1; m_word = '0; m_valid = 0;
            end else if ((m_word & rw) != '0) begin
                m_age = 0;
            end
        end else if (f) begin
            m_pend = 1;
        end
    endtask

    typedef struct {
        string        name;
        logic         l, f, a;
        logic [W-1:0] w;
        logic         ev, er, ee;
        logic [W-1:0] ew;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [W-1:0] w1, w2, w3, w3c, w4, w4c, w5, nop, rw_mask;
        w1  = mk(5, 0, 12, 0, 20, 0, 0, 0, 3, 0, 11'h2A5);
        w2  = mk(7, 1, 33, 1, 2, 1, 0, 0, 9, 5, 11'h123);
        w3  = mk(1, 0, 2, 0, 3, 0, 1, 0, 4, 2, 11'h011);
        w3c = mk(1, 0, 2, 0, 3, 0, 0, 0, 4, 2, 11'h011);
        w4  = mk(63, 1, 0, 0, 10, 1, 0, 1, 15, 7, 11'h7FF);
        w4c = mk(63, 1, 0, 0, 10, 1, 0, 0, 15, 7, 11'h7FF);
        w5  = mk(9, 0, 9, 0, 9, 0, 1, 1, 1, 1, 11'h001);
        nop = '0;

        vecs[0]  = '{"load_plain",    1, 0, 0, w1,  1, 1, 0, w1};
        vecs[1]  = '{"hold",          0, 0, 0, w2,  1, 1, 0, w1};
        vecs[2]  = '{"flush_load",    1, 1, 0, w2,  0, 1, 0, nop};
        vecs[3]  = '{"flush_alone",   0, 1, 0, w2,  0, 1, 0, nop};
        vecs[4]  = '{"pending_nop",   1, 0, 0, w2,  0, 1, 0, nop};
        vecs[5]  = '{"load_after",    1, 0, 0, w2,  1, 1, 0, w2};
        vecs[6]  = '{"load_rd",       1, 0, 0, w3,  1, 0, 0, w3};
        vecs[7]  = '{"wait1_ign_ld",  1, 0, 0, w1,  1, 0, 0, w3};
        vecs[8]  = '{"wait2",         0, 0, 0, w1,  1, 0, 0, w3};
        vecs[9]  = '{"ack_rd",        0, 0, 1, w1,  1, 1, 0, w3c};
        vecs[10] = '{"load_wr",       1, 0, 0, w4,  1, 0, 0, w4};
        vecs[11] = '{"ack_wr",        0, 0, 1, w1,  1, 1, 0, w4c};
        vecs[12] = '{"load_rdwr_err", 1, 0, 0, w5,  0, 0, 1, nop};
        vecs[13] = '{"err_sticky",    1, 0, 1, w1,  0, 0, 1, nop};

        // Reset state
        cyc(1, 0, 0, 0, '0);
        chk("reset_state", {1'b0, 1'b1, 1'b0, nop});

        for (int i = 0; i < 14; i++) begin
            cyc(0, vecs[i].l, vecs[i].f, vecs[i].a, vecs[i].w);
            chk(vecs[i].name, {vecs[i].ev, vecs[i].er, vecs[i].ee, vecs[i].ew});
        end

        // Timeout: no ack for TIMEOUT wait cycles
        cyc(1, 0, 0, 0, '0);
        chk("reset_from_err", {1'b0, 1'b1, 1'b0, nop});
        cyc(0, 1, 0, 0, w4);
        for (int i = 1; i < TIMEOUT; i++) begin
            cyc(0, 0, 0, 0, '0);
            if (i == TIMEOUT - 1) chk("wait_before_timeout", {1'b1, 1'b0, 1'b0, w4});
        end
        cyc(0, 0, 0, 0, '0);
        chk("timeout_err", {1'b0, 1'b0, 1'b1, nop});

        // Ack on the timeout edge wins
        cyc(1, 0, 0, 0, '0);
        cyc(0, 1, 0, 0, w4);
        for (int i = 1; i < TIMEOUT; i++) cyc(0, 0, 0, 0, '0);
        cyc(0, 0, 0, 1, '0);
        chk("ack_on_timeout_edge", {1'b1, 1'b1, 1'b0, w4c});

        // Flush during wait turns the next load into a NOP
        cyc(1, 0, 0, 0, '0);
        cyc(0, 1, 0, 0, w3);
        cyc(0, 0, 1, 0, '0);
        chk("flush_in_wait", {1'b1, 1'b0, 1'b0, w3});
        cyc(0, 0, 0, 1, '0);
        cyc(0, 1, 0, 0, w1);
        chk("pending_after_ack", {1'b0, 1'b1, 1'b0, nop});
        cyc(0, 1, 0, 0, w1);
        chk("load_after_pending", {1'b1, 1'b1, 1'b0, w1});

        // Reset mid-wait
        cyc(0, 1, 0, 0, w3);
        cyc(0, 0, 0, 0, '0);
        cyc(1, 1, 1, 1, w2);
        chk("reset_mid_wait", {1'b0, 1'b1, 1'b0, nop});

        // Randomized run against the model
        rw_mask = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        model_step(1, 0, 0, 0, '0);
        for (int i = 0; i < 3000; i++) begin
            logic         r, l, f, a;
            logic [W-1:0] w;
            int unsigned  sel;
            r = ($urandom_range(0, 99) < 2);
            l = ($urandom_range(0, 99) < 55);
            f = ($urandom_range(0, 99) < 10);
            a = ($urandom_range(0, 99) < 20);
            w = W'({$urandom, $urandom}) & ~rw_mask;
            sel = $urandom_range(0, 31);
            if (sel == 0) w = w | rw_mask;
            else if (sel <= 8) w = w | mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
            else if (sel <= 16) w = w | mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
            cyc(r, l, f, a, w);
            model_step(r, l, f, a, w);
            chk("random", {m_valid, (!m_dead && m_age < 0), m_dead, m_word});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
